// File: rtl/mult_seq_ft.sv
// Sequential radix-2 shift-add unsigned multiplier with valid/ready handshakes.
// Optional mod-3 residue fault detection is built when MULT_RESIDUE_CHECK_EN is defined.
module mult_seq_ft #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               fault,
  output logic               fault_sticky
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [WIDTH:0]     sum;
  logic               accept;
  logic               drain;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Upper half plus multiplicand, kept at WIDTH+1 bits so the carry shifts in.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (drain) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MULT_RESIDUE_CHECK_EN
  function automatic logic [1:0] add_mod3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Alternating-bit-sum: even bit positions weigh 1, odd positions weigh 2 (== -1 mod 3).
  function automatic logic [1:0] res_mod3(input logic [63:0] v);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (v[i]) begin
        r = add_mod3(r, i[0] ? 2'd2 : 2'd1);
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] mul_mod3(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] p;
    p = {2'b00, x} * {2'b00, y};
    return res_mod3(64'(p));
  endfunction

  logic [1:0] ra_q, ra_d;
  logic [1:0] rb_q, rb_d;
  logic       sticky_q, sticky_d;

  always_comb begin
    ra_d     = ra_q;
    rb_d     = rb_q;
    sticky_d = sticky_q;
    if (accept) begin
      ra_d = res_mod3(64'(a));
      rb_d = res_mod3(64'(b));
    end
    if (drain) begin
      sticky_d = sticky_q | fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q     <= '0;
      rb_q     <= '0;
      sticky_q <= 1'b0;
    end else begin
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      sticky_q <= sticky_d;
    end
  end

  assign fault        = out_valid && (res_mod3(64'(acc_q)) != mul_mod3(ra_q, rb_q));
  assign fault_sticky = sticky_q;
`else
  assign fault        = 1'b0;
  assign fault_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_ft.sv
// Self-checking bench for mult_seq_ft: table vectors, exhaustive 4-bit sweep,
// backpressure, mid-operation reset and residue fault injection.
module tb_mult_seq_ft;

`ifdef MULT_RESIDUE_CHECK_EN
  localparam logic FEXP = 1'b1;
`else
  localparam logic FEXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv4, ir4, ov4, or4, f4, fs4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv8, ir8, ov8, or8, f8, fs8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [7:0]  inj4;

  mult_seq_ft #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .product(p4), .fault(f4), .fault_sticky(fs4)
  );

  mult_seq_ft #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .fault(f8), .fault_sticky(fs8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] prod;
    logic       flt;
  } exp_t;
  exp_t sb4[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: compares at every output handshake of the 4-bit instance.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst_n) begin
      sb4.delete();
    end else if (ov4 && or4) begin
      if (sb4.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb4.pop_front();
        check("sb_product", p4, e.prod);
        check("sb_fault", f4, e.flt);
      end
    end
  end

  task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] ep,
                       input bit hold, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    a4 = ta;
    b4 = tb;
    iv4 = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ir4) begin
        sb4.push_back('{prod: ep, flt: 1'b0});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        got = 1;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    if (!hold || !got) iv4 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (ov4 && or4) got = 1;
    end
    if (!got) check(name, 64'd0, 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid4(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ov4) got = 1;
    end
    if (!got) check(name, 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  tc, prev;
    bit  got;
    logic [3:0] xa, xb;

    vecs[0] = '{a: 4'd0,  b: 4'd0,  prod: 8'd0};
    vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd15, prod: 8'd0};
    vecs[3] = '{a: 4'd15, b: 4'd1,  prod: 8'd15};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  prod: 8'd1};
    vecs[5] = '{a: 4'd13, b: 4'd11, prod: 8'd143};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  prod: 8'd64};
    vecs[7] = '{a: 4'd7,  b: 4'd9,  prod: 8'd63};

    iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
    inj4 = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready4", ir4, 1);
    check("rst_out_valid4", ov4, 0);
    check("rst_product4", p4, 0);
    check("rst_fault4", f4, 0);
    check("rst_sticky4", fs4, 0);
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_product8", p8, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 13*11 latency: valid exactly WIDTH edges after accept
    issue(4'd13, 4'd11, 8'd143, 0, tc);
    check("in_ready_low_after_accept", ir4, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("latency_out_valid", ov4, (k == 4));
    end
    check("dir_product", p4, 143);
    check("dir_fault", f4, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_drain", ir4, 1);
    check("out_valid_after_drain", ov4, 0);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].prod, 0, tc);
      wait_drain("vec_drain_timeout");
    end

    // Exhaustive, in_valid held high, accepts spaced WIDTH+2
    prev = -1;
    for (int i = 0; i < 256; i++) begin
      xa = i[7:4];
      xb = i[3:0];
      issue(xa, xb, {4'b0, xa} * {4'b0, xb}, 1, tc);
      if (i > 0) check("issue_interval", 64'(tc - prev), 64'd6);
      prev = tc;
    end
    iv4 = 1'b0;
    wait_drain("exh_drain_timeout");

    // 8-bit backpressure
    a8 = 8'd255; b8 = 8'd255; iv8 = 1'b1; or8 = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ir8) begin
        @(posedge clk);
        #1;
        got = 1;
      end
    end
    iv8 = 1'b0;
    if (!got) check("w8_accept_timeout", 64'd0, 64'd1);
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (ov8) got = 1;
    end
    if (!got) check("w8_valid_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("w8_held_product", p8, 65025);
      check("w8_held_valid", ov8, 1);
      check("w8_held_in_ready", ir8, 0);
    end
    @(posedge clk);
    #1;
    or8 = 1'b1;
    @(posedge clk);
    #1;
    check("w8_out_valid_after_drain", ov8, 0);
    check("w8_in_ready_after_drain", ir8, 1);
    or8 = 1'b0;

    // Reset during BUSY cycle 2 discards the operation
    issue(4'd9, 4'd7, 8'd63, 0, tc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov4, 0);
    check("midrst_in_ready", ir4, 1);
    check("midrst_product", p4, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'd3, 4'd5, 8'd15, 0, tc);
    wait_drain("post_rst_drain_timeout");

    // Fault injection: flip product LSB while held in DONE
    or4 = 1'b0;
    issue(4'd6, 4'd7, 8'd42, 0, tc);
    wait_valid4("inj_valid_timeout");
    @(posedge clk);
    #1;
    inj4 = p4 ^ 8'h01;
    force dut4.acc_q = inj4;
    if (sb4.size() > 0) begin
      sb4[sb4.size()-1].prod = 8'd43;
      sb4[sb4.size()-1].flt  = FEXP;
    end
    #1;
    check("inj_product", p4, 43);
    check("inj_fault", f4, FEXP);
    check("inj_sticky_before_drain", fs4, 0);
    @(posedge clk);
    #1;
    or4 = 1'b1;
    wait_drain("inj_drain_timeout");
    release dut4.acc_q;
    check("inj_sticky_after_drain", fs4, FEXP);
    check("fault_outside_done", f4, 0);
    issue(4'd2, 4'd2, 8'd4, 0, tc);
    wait_drain("clean_drain_timeout");
    check("sticky_persists", fs4, FEXP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
